// File: rtl/hazard_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_if
//  Purpose  : Bundles the pipeline-to-hazard-controller signals.
//             master : pipeline side (drives register indices and
//                      qualifiers, receives selects, stalls and flushes)
//             slave  : hazard controller side
//  Params   : REG_W - register index width
//  Revision : 1.0 - initial release
// ============================================================================
interface hazard_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] rs1_d, rs2_d;
  logic [REG_W-1:0] rs1_e, rs2_e, rd_e;
  logic [REG_W-1:0] rd_m, rd_w;
  logic             regwrite_m, regwrite_w;
  logic             load_e, pc_src_e, mdu_op_e;
  logic [1:0]       forward_a_e, forward_b_e;
  logic             stall_f, stall_d, stall_e;
  logic             flush_d, flush_e, flush_m;
  logic             mdu_done;
  logic [31:0]      stall_cnt, flush_cnt;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output regwrite_m, regwrite_w, load_e, pc_src_e, mdu_op_e,
    input  forward_a_e, forward_b_e,
    input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
    input  mdu_done, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  regwrite_m, regwrite_w, load_e, pc_src_e, mdu_op_e,
    output forward_a_e, forward_b_e,
    output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
    output mdu_done, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Forwarding select, load-use / branch stall-flush and MDU
//             sequencing controller for the 5-stage RISC-V pipeline.
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset
//             hz     - hazard_if.slave (register indices, qualifiers,
//                      forward selects, stalls, flushes, mdu_done,
//                      performance counters)
//  Params   : REG_W   - register index width
//             MDU_LAT - EX occupancy of an MDU op in cycles (>= 2)
//  Macro    : HAZARD_PERF_EN - builds saturating 32-bit stall/flush
//             counters; when undefined both counter ports read 0.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int MDU_LAT = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  hazard_if.slave   hz
);

  localparam int CNT_W = $clog2(MDU_LAT) + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] w_fwd_a, w_fwd_b;
  logic       w_lw_stall;
  logic       w_mdu_busy;
  logic       w_mdu_done;
  logic       w_stall_fd, w_stall_e;
  logic       w_flush_d, w_flush_e, w_flush_m;

  // --------------------------------------------------------------------------
  // Forwarding: MEM result takes priority over WB; x0 is never forwarded.
  // --------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] rs,
    input logic             wr_m,
    input logic [REG_W-1:0] rdm,
    input logic             wr_w,
    input logic [REG_W-1:0] rdw
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rdm != '0) && (rdm == rs)) begin
      sel = 2'b10;
    end else if (wr_w && (rdw != '0) && (rdw == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    w_fwd_a = fwd_sel(hz.rs1_e, hz.regwrite_m, hz.rd_m, hz.regwrite_w, hz.rd_w);
    w_fwd_b = fwd_sel(hz.rs2_e, hz.regwrite_m, hz.rd_m, hz.regwrite_w, hz.rd_w);
  end

  // --------------------------------------------------------------------------
  // MDU sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (hz.mdu_op_e) begin
          state_d = BUSY;
          // The entry cycle is itself a busy cycle, hence LAT-2.
          cnt_d   = CNT_W'(MDU_LAT - 2);
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Stall / flush generation. Every stall, flush and done is qualified with
  // rst_n so they fall the instant reset asserts, even with an MDU op on the
  // EX inputs.
  // --------------------------------------------------------------------------
  always_comb begin
    w_lw_stall = hz.load_e && (hz.rd_e != '0) &&
                 ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

    w_mdu_busy = rst_n &&
                 (((state_q == IDLE) && hz.mdu_op_e) ||
                  ((state_q == BUSY) && (cnt_q != '0)));
    w_mdu_done = rst_n && (state_q == BUSY) && (cnt_q == '0);

    w_stall_fd = rst_n && (w_lw_stall || w_mdu_busy);
    w_stall_e  = w_mdu_busy;
    w_flush_m  = w_mdu_busy;
    // While busy the EX slot holds the MDU op, so branch and load-use
    // requests from it are meaningless and masked.
    w_flush_d  = rst_n && hz.pc_src_e && !w_mdu_busy;
    w_flush_e  = rst_n && (w_lw_stall || hz.pc_src_e) && !w_mdu_busy;
  end

  assign hz.forward_a_e = w_fwd_a;
  assign hz.forward_b_e = w_fwd_b;
  assign hz.stall_f     = w_stall_fd;
  assign hz.stall_d     = w_stall_fd;
  assign hz.stall_e     = w_stall_e;
  assign hz.flush_d     = w_flush_d;
  assign hz.flush_e     = w_flush_e;
  assign hz.flush_m     = w_flush_m;
  assign hz.mdu_done    = w_mdu_done;

  // --------------------------------------------------------------------------
  // Optional performance counters (saturating)
  // --------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (w_stall_fd && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (w_flush_e && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = 32'd0;
  assign hz.flush_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Self-checking bench for hazard_ctrl: directed scenarios plus
//             randomized traffic against a cycle-age reference model.
//             Honours HAZARD_PERF_EN the same way as the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
  localparam int LAT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  hazard_if #(.REG_W(5)) hif ();

  hazard_ctrl #(.REG_W(5), .MDU_LAT(LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hif.slave)
  );

  // {fwd_a, fwd_b, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, done}
  wire [10:0] obs = {hif.forward_a_e, hif.forward_b_e, hif.stall_f, hif.stall_d,
                     hif.stall_e, hif.flush_d, hif.flush_e, hif.flush_m,
                     hif.mdu_done};

  // --------------------------------------------------------------------------
  // Reference model: m_age = cycles since the current MDU op entered EX
  // (-1 when no op is in flight).
  // --------------------------------------------------------------------------
  int          m_age  = -1;
  logic [31:0] m_scnt = 0;
  logic [31:0] m_fcnt = 0;

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (hif.regwrite_m && hif.rd_m != 0 && hif.rd_m == rs) return 2'b10;
    if (hif.regwrite_w && hif.rd_w != 0 && hif.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_busy();
    if (!rst_n) return 1'b0;
    if (m_age < 0) return hif.mdu_op_e;
    return m_age <= LAT - 2;
  endfunction

  function automatic bit m_lw();
    return rst_n && hif.load_e && hif.rd_e != 0 &&
           (hif.rd_e == hif.rs1_d || hif.rd_e == hif.rs2_d);
  endfunction

  function automatic bit m_stall();
    return m_lw() || m_busy();
  endfunction

  function automatic bit m_flush_e();
    return rst_n && (m_lw() || hif.pc_src_e) && !m_busy();
  endfunction

  function automatic logic [10:0] model_out();
    bit done, fd;
    done = rst_n && (m_age == LAT - 1);
    fd   = rst_n && hif.pc_src_e && !m_busy();
    return {m_fwd(hif.rs1_e), m_fwd(hif.rs2_e), m_stall(), m_stall(),
            m_busy(), fd, m_flush_e(), m_busy(), done};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age  <= -1;
      m_scnt <= 0;
      m_fcnt <= 0;
    end else begin
      if (m_age < 0) m_age <= hif.mdu_op_e ? 1 : -1;
      else if (m_age == LAT - 1) m_age <= -1;
      else m_age <= m_age + 1;
      if (m_stall() && m_scnt != 32'hFFFF_FFFF) m_scnt <= m_scnt + 1;
      if (m_flush_e() && m_fcnt != 32'hFFFF_FFFF) m_fcnt <= m_fcnt + 1;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic drive_idle();
    hif.rs1_d = 0; hif.rs2_d = 0; hif.rs1_e = 0; hif.rs2_e = 0;
    hif.rd_e = 0; hif.rd_m = 0; hif.rd_w = 0;
    hif.regwrite_m = 0; hif.regwrite_w = 0;
    hif.load_e = 0; hif.pc_src_e = 0; hif.mdu_op_e = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    vectors++;
    if (obs !== 11'd0) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", obs, 11'd0);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({hif.stall_cnt, hif.flush_cnt} !== 64'd0) begin
      errors++; $display("FAIL reset_counters: got %h/%h want 0/0", hif.stall_cnt, hif.flush_cnt);
    end
    @(negedge clk); #2;
    vectors++;
    if (obs !== 11'd0) begin
      errors++; $display("FAIL post_reset_idle: got %b want %b", obs, 11'd0);
    end
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    drive_idle();
    hif.rs1_e = 5; hif.rs2_e = 5; hif.rd_m = 5; hif.rd_w = 5;
    hif.regwrite_m = 1; hif.regwrite_w = 1;
    #2; vectors++;
    if ({hif.forward_a_e, hif.forward_b_e} !== 4'b1010) begin
      errors++; $display("FAIL fwd_mem_prio: got %b_%b want 10_10", hif.forward_a_e, hif.forward_b_e);
    end
    @(negedge clk);
    hif.regwrite_m = 0;
    #2; vectors++;
    if ({hif.forward_a_e, hif.forward_b_e} !== 4'b0101) begin
      errors++; $display("FAIL fwd_wb: got %b_%b want 01_01", hif.forward_a_e, hif.forward_b_e);
    end
    @(negedge clk);
    hif.regwrite_m = 1; hif.rd_m = 0; hif.rd_w = 0;
    #2; vectors++;
    if ({hif.forward_a_e, hif.forward_b_e} !== 4'b0000) begin
      errors++; $display("FAIL fwd_x0: got %b_%b want 00_00", hif.forward_a_e, hif.forward_b_e);
    end
    @(negedge clk);
    hif.rd_m = 3; hif.rd_w = 9; hif.rs1_e = 9; hif.rs2_e = 3;
    #2; vectors++;
    if ({hif.forward_a_e, hif.forward_b_e} !== 4'b0110) begin
      errors++; $display("FAIL fwd_split: got %b_%b want 01_10", hif.forward_a_e, hif.forward_b_e);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    drive_idle();
    hif.load_e = 1; hif.rd_e = 7; hif.rs2_d = 7;
    #2; vectors++;
    // {stall_f, stall_d, stall_e, flush_e}
    if ({hif.stall_f, hif.stall_d, hif.stall_e, hif.flush_e} !== 4'b1101) begin
      errors++; $display("FAIL load_use: got %b want 1101",
                         {hif.stall_f, hif.stall_d, hif.stall_e, hif.flush_e});
    end
    @(negedge clk);
    hif.rd_e = 0; hif.rs2_d = 0;
    #2; vectors++;
    if ({hif.stall_f, hif.stall_d, hif.stall_e, hif.flush_e} !== 4'b0000) begin
      errors++; $display("FAIL load_use_x0: got %b want 0000",
                         {hif.stall_f, hif.stall_d, hif.stall_e, hif.flush_e});
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    drive_idle();
    hif.pc_src_e = 1;
    #2; vectors++;
    // {flush_d, flush_e, stall_f}
    if ({hif.flush_d, hif.flush_e, hif.stall_f} !== 3'b110) begin
      errors++; $display("FAIL branch: got %b want 110", {hif.flush_d, hif.flush_e, hif.stall_f});
    end
    @(negedge clk);
    hif.load_e = 1; hif.rd_e = 4; hif.rs1_d = 4;
    #2; vectors++;
    if ({hif.flush_d, hif.flush_e, hif.stall_f} !== 3'b111) begin
      errors++; $display("FAIL branch_lw: got %b want 111", {hif.flush_d, hif.flush_e, hif.stall_f});
    end
  endtask

  task automatic test_mdu();
    logic [5:0] want;
    // Single op, branch pulse in its second cycle. Fields:
    // {stall_f, stall_d, stall_e, flush_m, flush_d, mdu_done}
    for (int k = 0; k < LAT + 1; k++) begin
      @(negedge clk);
      drive_idle();
      hif.mdu_op_e = (k == 0);
      hif.pc_src_e = (k == 1);
      #2;
      if (k <= LAT - 2)      want = 6'b111100;
      else if (k == LAT - 1) want = 6'b000001;
      else                   want = 6'b000000;
      vectors++;
      if ({hif.stall_f, hif.stall_d, hif.stall_e, hif.flush_m, hif.flush_d, hif.mdu_done} !== want) begin
        errors++; $display("FAIL mdu_seq k=%0d: got %b want %b", k,
          {hif.stall_f, hif.stall_d, hif.stall_e, hif.flush_m, hif.flush_d, hif.mdu_done}, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] want;
    // Op held on the EX inputs: a new op re-enters every LAT cycles.
    for (int k = 0; k < 2 * LAT; k++) begin
      @(negedge clk);
      drive_idle();
      hif.mdu_op_e = 1;
      #2;
      want = ((k % LAT) == LAT - 1) ? 2'b01 : 2'b10;
      vectors++;
      if ({hif.stall_e, hif.mdu_done} !== want) begin
        errors++; $display("FAIL b2b k=%0d: got %b want %b", k, {hif.stall_e, hif.mdu_done}, want);
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset_mid_mdu();
    @(negedge clk);
    drive_idle();
    hif.mdu_op_e = 1;
    @(negedge clk);
    hif.mdu_op_e = 0;
    #2; vectors++;
    if ({hif.stall_f, hif.stall_e, hif.flush_m} !== 3'b111) begin
      errors++; $display("FAIL mid_mdu_busy: got %b want 111", {hif.stall_f, hif.stall_e, hif.flush_m});
    end
    rst_n = 1'b0;
    #1; vectors++;
    if (obs[8:0] !== 9'd0) begin
      errors++; $display("FAIL async_reset_drop: got %b want 0", obs[8:0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 1; k++) begin
      @(negedge clk); #2;
      vectors++;
      if (obs[8:0] !== 9'd0) begin
        errors++; $display("FAIL post_reset_quiet k=%0d: got %b want 0", k, obs[8:0]);
      end
    end
  endtask

  task automatic test_perf();
    logic [63:0] want;
    do_reset();
    @(negedge clk);
    hif.mdu_op_e = 1;
    @(negedge clk);
    hif.mdu_op_e = 0;
    repeat (LAT - 1) @(negedge clk);
    hif.load_e = 1; hif.rd_e = 6; hif.rs1_d = 6;
    @(negedge clk);
    drive_idle();
    @(negedge clk); #2;
`ifdef HAZARD_PERF_EN
    want = {32'd4, 32'd1};
`else
    want = 64'd0;
`endif
    vectors++;
    if ({hif.stall_cnt, hif.flush_cnt} !== want) begin
      errors++; $display("FAIL perf_counts: got %0d/%0d want %0d/%0d",
                         hif.stall_cnt, hif.flush_cnt, want[63:32], want[31:0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      hif.rs1_d = 5'($urandom_range(3)); hif.rs2_d = 5'($urandom_range(3));
      hif.rs1_e = 5'($urandom_range(3)); hif.rs2_e = 5'($urandom_range(3));
      hif.rd_e  = 5'($urandom_range(3)); hif.rd_m  = 5'($urandom_range(3));
      hif.rd_w  = 5'($urandom_range(3));
      hif.regwrite_m = 1'($urandom); hif.regwrite_w = 1'($urandom);
      hif.load_e     = 1'($urandom); hif.pc_src_e   = ($urandom_range(3) == 0);
      hif.mdu_op_e   = ($urandom_range(5) == 0);
      #2; vectors++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL random n=%0d: got %b want %b", n, obs, model_out());
      end
`ifdef HAZARD_PERF_EN
      vectors++;
      if ({hif.stall_cnt, hif.flush_cnt} !== {m_scnt, m_fcnt}) begin
        errors++; $display("FAIL random_perf n=%0d: got %0d/%0d want %0d/%0d",
                           n, hif.stall_cnt, hif.flush_cnt, m_scnt, m_fcnt);
      end
`else
      vectors++;
      if ({hif.stall_cnt, hif.flush_cnt} !== 64'd0) begin
        errors++; $display("FAIL random_perf_off n=%0d: got %0d/%0d want 0/0",
                           n, hif.stall_cnt, hif.flush_cnt);
      end
`endif
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mdu();
    test_back_to_back();
    test_reset_mid_mdu();
    test_perf();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
